// File: rtl/cr_sys_lpmd_ctrl.sv
// Low-power mode sequencer: drains the BIU, handshakes with the SoC power controller,
// sleeps until a wakeup source fires, then settles before resuming. All outputs registered.
module cr_sys_lpmd_ctrl #(
  parameter int DRAIN_TMO  = 255,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 8
) (
  input  logic       forever_cpuclk,
  input  logic       cpurst,
  input  logic       cp0_sysio_lpmd_req,
  input  logic [1:0] cp0_sysio_lpmd_b,
  input  logic       cp0_sysio_int_wk_en,
  input  logic       biu_sysio_idle,
  input  logic       pad_sysio_lpmd_ack,
  input  logic       pad_cpu_ext_int_b,
  input  logic       pad_cpu_nmi,
  input  logic       pad_cpu_wakeup_event,
  input  logic       pad_sysio_dbgrq_b,
  output logic       sysio_biu_drain_req,
  output logic       sysio_pad_lpmd_req,
  output logic [1:0] sysio_pad_lpmd_b,
  output logic       sysio_iu_lpmd_busy,
  output logic       sysio_iu_wk_done,
  output logic       sysio_cp0_lpmd_abort
);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_REQ    = 3'd2,
    ST_SLEEP  = 3'd3,
    ST_EXIT   = 3'd4,
    ST_SETTLE = 3'd5
  } state_t;

  localparam logic [1:0]       MODE_RUN   = 2'b11;
  localparam logic [CNT_W-1:0] TMO_C      = CNT_W'(DRAIN_TMO);
  localparam logic [CNT_W-1:0] SET_LAST_C = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wk_pend_q, wk_pend_d;
  logic [1:0]       mode_q, mode_d;
  logic             drain_req_q, lpmd_req_q, busy_q, done_q, abort_q;
  logic             done_d, abort_d;
  logic [1:0]       lpmd_b_q;
  logic             wk;

  assign wk = pad_cpu_nmi | pad_cpu_wakeup_event | ~pad_sysio_dbgrq_b |
              (cp0_sysio_int_wk_en & ~pad_cpu_ext_int_b);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wk_pend_d = wk_pend_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (cp0_sysio_lpmd_req && cp0_sysio_lpmd_b != MODE_RUN) begin
          mode_d  = cp0_sysio_lpmd_b;
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        // Wakeup outranks both timeout and idle: an abort is cheaper than a wasted handshake.
        if (wk || cnt_q == TMO_C) begin
          abort_d = 1'b1;
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (biu_sysio_idle) begin
          state_d = ST_REQ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_REQ: begin
        if (wk) wk_pend_d = 1'b1;
        if (pad_sysio_lpmd_ack) begin
          state_d = (wk_pend_q || wk) ? ST_EXIT : ST_SLEEP;
          cnt_d   = '0;
        end
      end
      ST_SLEEP: begin
        if (wk) begin
          state_d = ST_EXIT;
          cnt_d   = '0;
        end
      end
      ST_EXIT: begin
        if (!pad_sysio_lpmd_ack) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SET_LAST_C) begin
          done_d  = 1'b1;
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
    if (state_d == ST_RUN && state_q != ST_RUN) wk_pend_d = 1'b0;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      wk_pend_q   <= 1'b0;
      mode_q      <= MODE_RUN;
      drain_req_q <= 1'b0;
      lpmd_req_q  <= 1'b0;
      lpmd_b_q    <= MODE_RUN;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wk_pend_q   <= wk_pend_d;
      mode_q      <= mode_d;
      // Outputs decode the next state so they line up with the state register.
      drain_req_q <= (state_d != ST_RUN);
      busy_q      <= (state_d != ST_RUN);
      lpmd_req_q  <= (state_d == ST_REQ) || (state_d == ST_SLEEP);
      lpmd_b_q    <= (state_d == ST_REQ || state_d == ST_SLEEP || state_d == ST_EXIT)
                     ? mode_d : MODE_RUN;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign sysio_biu_drain_req  = drain_req_q;
  assign sysio_pad_lpmd_req   = lpmd_req_q;
  assign sysio_pad_lpmd_b     = lpmd_b_q;
  assign sysio_iu_lpmd_busy   = busy_q;
  assign sysio_iu_wk_done     = done_q;
  assign sysio_cp0_lpmd_abort = abort_q;

endmodule
